// File: rtl/seg_display_arbiter.sv
// Round-robin, hold-time-protected sharing of one 8-digit seven-segment display.
// Optional per-digit blinking is compiled in with `define SEG_BLINK_EN.
module seg_display_arbiter #(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 1024,
  parameter int BLINK_DIV   = 4194304
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [8*NREQ-1:0]    req_blink,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          disp_data,
  output logic [7:0]           disp_blank,
  output logic [1:0]           disp_owner,
  output logic                 disp_valid
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_OPEN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_q, last_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [31:0]     data_q, data_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            valid_q, valid_d;

  logic [NREQ-1:0] req_eff, owner_oh;
  logic [2:0]      pick_any, pick_other;
  logic            grant, latch_own;
  logic [1:0]      grant_idx, sel;

  // Returns {found, index}: first set bit of mask searching from (from+1) mod NREQ.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] mask, input logic [1:0] from);
    logic [2:0] res;
    int         idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(from) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (j == idx && mask[j]) res = {1'b1, 2'(j)};
      end
    end
    return res;
  endfunction

  // A request seen while its own ack is out is the tail of the finished handshake.
  always_comb begin
    for (int i = 0; i < NREQ; i++) owner_oh[i] = (2'(i) == owner_q);
    req_eff    = req & ~ack_q;
    pick_any   = rr_pick(req_eff, last_q);
    pick_other = rr_pick(req_eff & ~owner_oh, last_q);
  end

`ifdef SEG_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    blank_q, blank_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    blank_d = mask_d & {8{phase_d}};
  end
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    data_d     = data_q;
    ack_d      = '0;
    valid_d    = valid_q;
    grant      = 1'b0;
    grant_idx  = '0;
    latch_own  = 1'b0;
`ifdef SEG_BLINK_EN
    mask_d     = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_any[2]) begin
          grant     = 1'b1;
          grant_idx = pick_any[1:0];
        end
      end
      S_LOCK: begin
        latch_own = |(req_eff & owner_oh);
        if (hold_cnt_q == '0) state_d = S_OPEN;
        else                  hold_cnt_d = hold_cnt_q - HW'(1);
      end
      S_OPEN: begin
        if (pick_other[2]) begin
          grant     = 1'b1;
          grant_idx = pick_other[1:0];
        end else begin
          latch_own = |(req_eff & owner_oh);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant) begin
      owner_d    = grant_idx;
      last_d     = grant_idx;
      valid_d    = 1'b1;
      hold_cnt_d = HW'(HOLD_CYCLES - 1);
      state_d    = S_LOCK;
    end

    sel = grant ? grant_idx : owner_q;
    if (grant || latch_own) begin
      for (int i = 0; i < NREQ; i++) begin
        if (2'(i) == sel) begin
          data_d   = req_data[32*i +: 32];
          ack_d[i] = 1'b1;
`ifdef SEG_BLINK_EN
          mask_d   = req_blink[8*i +: 8];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      last_q      <= 2'(NREQ - 1);
      hold_cnt_q  <= '0;
      data_q      <= 32'hFFFF_FFFF;
      ack_q       <= '0;
      valid_q     <= 1'b0;
`ifdef SEG_BLINK_EN
      mask_q      <= '0;
      blank_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
`ifdef SEG_BLINK_EN
      mask_q      <= mask_d;
      blank_q     <= blank_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
`endif
    end
  end

`ifdef SEG_BLINK_EN
  assign disp_blank = blank_q;
`else
  logic unused_blink;
  assign unused_blink = ^req_blink;
  assign disp_blank   = '0;
`endif

  assign ack        = ack_q;
  assign disp_data  = data_q;
  assign disp_owner = owner_q;
  assign disp_valid = valid_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (NREQ=3, HOLD_CYCLES=8, BLINK_DIV=4).
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [31:0] d0, d1, d2;
  logic [7:0]  b0, b1, b2;
  logic [95:0] req_data;
  logic [23:0] req_blink;
  logic [2:0]  ack;
  logic [31:0] disp_data;
  logic [7:0]  disp_blank;
  logic [1:0]  disp_owner;
  logic        disp_valid;

  int checks = 0;
  int errors = 0;

  assign req_data  = {d2, d1, d0};
  assign req_blink = {b2, b1, b0};

  always #5 clk = ~clk;

  seg_display_arbiter #(.NREQ(3), .HOLD_CYCLES(8), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_blink(req_blink),
    .ack(ack), .disp_data(disp_data), .disp_blank(disp_blank),
    .disp_owner(disp_owner), .disp_valid(disp_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] bl [16];
    rst = 1'b1; req = '0;
    d0 = '0; d1 = '0; d2 = '0; b0 = '0; b1 = '0; b2 = '0;
    tick; tick;
    chk("rst_data",  disp_data,  32'hFFFF_FFFF);
    chk("rst_valid", {31'd0, disp_valid}, 32'd0);
    chk("rst_ack",   {29'd0, ack}, 32'd0);
    chk("rst_owner", {30'd0, disp_owner}, 32'd0);
    chk("rst_blank", {24'd0, disp_blank}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick;
      chk("idle_ack",   {29'd0, ack}, 32'd0);
      chk("idle_valid", {31'd0, disp_valid}, 32'd0);
      chk("idle_data",  disp_data, 32'hFFFF_FFFF);
    end

    // IDLE grant: requesters 0 and 1 together, search starts at 0
    d0 = 32'h1234_5678; d1 = 32'h9ABC_DEF0; req = 3'b011;
    tick;
    chk("g0_ack",   {29'd0, ack}, 32'h1);
    chk("g0_data",  disp_data, 32'h1234_5678);
    chk("g0_owner", {30'd0, disp_owner}, 32'd0);
    chk("g0_valid", {31'd0, disp_valid}, 32'd1);

    // Requester 2 waits out the hold; owner update during LOCK acks in one cycle
    req = 3'b100; d2 = 32'hC0FF_EE02;
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k == 3) begin
        chk("lock_upd_ack",  {29'd0, ack}, 32'h1);
        chk("lock_upd_data", disp_data, 32'h0000_0A0A);
        req[0] = 1'b0;
      end else if (k == 9) begin
        chk("take2_ack",   {29'd0, ack}, 32'h4);
        chk("take2_owner", {30'd0, disp_owner}, 32'd2);
        chk("take2_data",  disp_data, 32'hC0FF_EE02);
      end else begin
        chk("lock_wait_ack", {29'd0, ack}, 32'd0);
        chk("lock_owner",    {30'd0, disp_owner}, 32'd0);
      end
      if (k == 2) begin
        d0 = 32'h0000_0A0A; req[0] = 1'b1;
      end
    end
    req = '0;

    // In OPEN with owner 2, non-owner 0 beats the owner's simultaneous request
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("hold2_ack", {29'd0, ack}, 32'd0);
    end
    d0 = 32'h5555_AAAA; req = 3'b101;
    tick;
    chk("prio_ack",   {29'd0, ack}, 32'h1);
    chk("prio_owner", {30'd0, disp_owner}, 32'd0);
    chk("prio_data",  disp_data, 32'h5555_AAAA);
    req = 3'b100;
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k == 9) begin
        chk("late2_ack",   {29'd0, ack}, 32'h4);
        chk("late2_owner", {30'd0, disp_owner}, 32'd2);
      end else begin
        chk("late2_wait", {29'd0, ack}, 32'd0);
      end
    end
    req = '0;

    // Owner 1 mid-LOCK, then asynchronous reset
    for (int k = 1; k <= 8; k++) tick;
    d1 = 32'h1111_2222; b1 = 8'h0F; req = 3'b010;
    tick;
    chk("g1_ack",   {29'd0, ack}, 32'h2);
    chk("g1_owner", {30'd0, disp_owner}, 32'd1);
    req = '0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ack",   {29'd0, ack}, 32'd0);
    chk("arst_data",  disp_data, 32'hFFFF_FFFF);
    chk("arst_valid", {31'd0, disp_valid}, 32'd0);
    chk("arst_owner", {30'd0, disp_owner}, 32'd0);
    tick;
    rst = 1'b0;
    d1 = 32'h3333_4444; req = 3'b010;
    tick;
    chk("reg1_ack",   {29'd0, ack}, 32'h2);
    chk("reg1_owner", {30'd0, disp_owner}, 32'd1);
    chk("reg1_data",  disp_data, 32'h3333_4444);
    chk("reg1_valid", {31'd0, disp_valid}, 32'd1);
    req = '0;

    // Mask 8'h0F is now latched for owner 1
    for (int i = 0; i < 16; i++) begin
      bl[i] = disp_blank;
      tick;
    end
`ifdef SEG_BLINK_EN
    for (int i = 0; i < 16; i++) begin
      chk("blink_val", {31'd0, (bl[i] == 8'h00) || (bl[i] == 8'h0F)}, 32'd1);
    end
    for (int i = 0; i < 12; i++) begin
      chk("blink_alt", {24'd0, bl[i+4]}, {24'd0, bl[i] ^ 8'h0F});
    end
`else
    for (int i = 0; i < 16; i++) begin
      chk("blank_off", {24'd0, bl[i]}, 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
